// File: rtl/alu_arbiter_pkg.sv
// Shared ALU definitions: operand width default, fun3 opcodes and arbiter state encoding.
// Imported by the arbiter, its interface and the requesters' environment.
package alu_arbiter_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;

    localparam logic [2:0] FUN3_ADD_SUB = 3'b000;
    localparam logic [2:0] FUN3_SLL     = 3'b001;
    localparam logic [2:0] FUN3_SLT     = 3'b010;
    localparam logic [2:0] FUN3_SLTU    = 3'b011;
    localparam logic [2:0] FUN3_XOR     = 3'b100;
    localparam logic [2:0] FUN3_SR      = 3'b101;
    localparam logic [2:0] FUN3_OR      = 3'b110;
    localparam logic [2:0] FUN3_AND     = 3'b111;

    typedef enum logic {
        StIdle = 1'b0,
        StHold = 1'b1
    } arb_state_e;

    // Owner index to per-requester one-hot handshake vector.
    function automatic logic [1:0] owner_onehot(input logic owner);
        return owner ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response handshakes of the two ALU clients plus the shared-ALU connection.
// slave = arbiter side, master = environment side (requesters and the ALU).
interface alu_arbiter_if #(
    parameter int unsigned XLEN = alu_arbiter_pkg::XLEN_DEFAULT
) ();

    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [XLEN-1:0] req0_op1;
    logic [XLEN-1:0] req0_op2;
    logic [XLEN-1:0] req1_op1;
    logic [XLEN-1:0] req1_op2;
    logic [2:0]      req0_fun3;
    logic [2:0]      req1_fun3;
    logic            req0_aux;
    logic            req1_aux;

    logic [1:0]      resp_valid;
    logic [1:0]      resp_ready;
    logic [XLEN-1:0] resp_result;

    logic [XLEN-1:0] alu_op1;
    logic [XLEN-1:0] alu_op2;
    logic [2:0]      alu_fun3;
    logic            alu_aux;
    logic [XLEN-1:0] alu_result;

    modport slave (
        input  req_valid, req0_op1, req0_op2, req1_op1, req1_op2,
               req0_fun3, req1_fun3, req0_aux, req1_aux,
               resp_ready, alu_result,
        output req_ready, resp_valid, resp_result,
               alu_op1, alu_op2, alu_fun3, alu_aux
    );

    modport master (
        output req_valid, req0_op1, req0_op2, req1_op1, req1_op2,
               req0_fun3, req1_fun3, req0_aux, req1_aux,
               resp_ready, alu_result,
        input  req_ready, resp_valid, resp_result,
               alu_op1, alu_op2, alu_fun3, alu_aux
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way arbiter, round-robin or fixed priority to requester 0.
// The priority pointer only moves when the caller reports an accepted grant.
module rr_arb2 #(
    parameter bit RR_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] valid,
    input  logic       accept,
    output logic [1:0] grant
);

    // prio_q = 1: requester 1 wins a tie.
    logic prio_q, prio_d;
    logic pick1;

    always_comb begin
        pick1 = valid[1] && (!valid[0] || (RR_EN && prio_q));
        grant = 2'b00;
        if (en) begin
            grant = {pick1, valid[0] && !pick1};
        end
    end

    always_comb begin
        prio_d = prio_q;
        if (accept) begin
            prio_d = grant[0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters and holds each result in a
// register until its owner takes it; a new op may be accepted in the handshake cycle.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEFAULT,
    parameter bit          RR_EN = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    alu_arbiter_if.slave  bus
);

    arb_state_e      state_q, state_d;
    logic            owner_q, owner_d;
    logic [XLEN-1:0] result_q, result_d;

    logic [1:0] grant;
    logic       arb_en;
    logic       accept;
    logic       resp_done;

    assign resp_done = (state_q == StHold) && bus.resp_ready[owner_q];
    // rst gates the grant combinationally so nothing is offered while reset is held.
    assign arb_en    = !rst && ((state_q == StIdle) || resp_done);
    assign accept    = |grant;

    rr_arb2 #(
        .RR_EN (RR_EN)
    ) u_arb (
        .clk    (clk),
        .rst    (rst),
        .en     (arb_en),
        .valid  (bus.req_valid),
        .accept (accept),
        .grant  (grant)
    );

    assign bus.req_ready   = grant;
    assign bus.resp_result = result_q;

    always_comb begin
        bus.resp_valid = 2'b00;
        if (state_q == StHold) begin
            bus.resp_valid = owner_onehot(owner_q);
        end
    end

    always_comb begin
        bus.alu_op1  = '0;
        bus.alu_op2  = '0;
        bus.alu_fun3 = 3'b000;
        bus.alu_aux  = 1'b0;
        unique case (grant)
            2'b01: begin
                bus.alu_op1  = bus.req0_op1;
                bus.alu_op2  = bus.req0_op2;
                bus.alu_fun3 = bus.req0_fun3;
                bus.alu_aux  = bus.req0_aux;
            end
            2'b10: begin
                bus.alu_op1  = bus.req1_op1;
                bus.alu_op2  = bus.req1_op2;
                bus.alu_fun3 = bus.req1_fun3;
                bus.alu_aux  = bus.req1_aux;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        result_d = result_q;
        if (accept) begin
            state_d  = StHold;
            owner_d  = grant[1];
            result_d = bus.alu_result;
        end else if (resp_done) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            owner_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench: a round-robin and a fixed-priority arbiter see identical stimulus,
// each with its own reference ALU on the alu_* side.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    alu_arbiter_if #(.XLEN(32)) bus0 ();
    alu_arbiter_if #(.XLEN(32)) bus1 ();

    alu_arbiter #(.XLEN(32), .RR_EN(1'b1)) u_dut_rr (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    alu_arbiter #(.XLEN(32), .RR_EN(1'b0)) u_dut_fix (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] alu_model(input logic [2:0] f, input logic aux,
                                              input logic [31:0] a, input logic [31:0] b);
        case (f)
            FUN3_ADD_SUB: return aux ? a - b : a + b;
            FUN3_SLL:     return a << b[4:0];
            FUN3_SLT:     return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            FUN3_SLTU:    return (a < b) ? 32'd1 : 32'd0;
            FUN3_XOR:     return a ^ b;
            FUN3_SR:      return aux ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            FUN3_OR:      return a | b;
            default:      return a & b;
        endcase
    endfunction

    always_comb bus0.alu_result = alu_model(bus0.alu_fun3, bus0.alu_aux, bus0.alu_op1, bus0.alu_op2);
    always_comb bus1.alu_result = alu_model(bus1.alu_fun3, bus1.alu_aux, bus1.alu_op1, bus1.alu_op2);

    assign bus1.req_valid  = bus0.req_valid;
    assign bus1.req0_op1   = bus0.req0_op1;
    assign bus1.req0_op2   = bus0.req0_op2;
    assign bus1.req1_op1   = bus0.req1_op1;
    assign bus1.req1_op2   = bus0.req1_op2;
    assign bus1.req0_fun3  = bus0.req0_fun3;
    assign bus1.req1_fun3  = bus0.req1_fun3;
    assign bus1.req0_aux   = bus0.req0_aux;
    assign bus1.req1_aux   = bus0.req1_aux;
    assign bus1.resp_ready = bus0.resp_ready;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [2:0]  f;
        logic        aux;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
    } vec_t;

    vec_t vecs [7];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{FUN3_SLL,  1'b0, 32'd1,         32'd4,      32'd16};
        vecs[1] = '{FUN3_SLT,  1'b0, 32'hFFFF_FFFF, 32'd1,      32'd1};
        vecs[2] = '{FUN3_SLTU, 1'b0, 32'hFFFF_FFFF, 32'd1,      32'd0};
        vecs[3] = '{FUN3_SR,   1'b1, 32'h8000_0000, 32'd4,      32'hF800_0000};
        vecs[4] = '{FUN3_SR,   1'b0, 32'h8000_0000, 32'd4,      32'h0800_0000};
        vecs[5] = '{FUN3_XOR,  1'b0, 32'h0000_F0F0, 32'h0FF0,   32'h0000_FF00};
        vecs[6] = '{FUN3_AND,  1'b0, 32'h0000_F0F0, 32'h0FF0,   32'h0000_00F0};

        // Reset with both requesters pushing: nothing may be granted or forwarded.
        rst = 1'b1;
        bus0.req_valid  = 2'b11;
        bus0.req0_op1   = 32'h11;  bus0.req0_op2 = 32'h22;
        bus0.req1_op1   = 32'h33;  bus0.req1_op2 = 32'h44;
        bus0.req0_fun3  = 3'b110;  bus0.req1_fun3 = 3'b111;
        bus0.req0_aux   = 1'b1;    bus0.req1_aux  = 1'b1;
        bus0.resp_ready = 2'b11;
        step();
        check("rst_req_ready", 64'(bus0.req_ready), 64'h0);
        check("rst_resp_valid", 64'(bus0.resp_valid), 64'h0);
        check("rst_resp_result", 64'(bus0.resp_result), 64'h0);
        check("rst_alu_op1", 64'(bus0.alu_op1), 64'h0);
        check("rst_alu_fun3", 64'(bus0.alu_fun3), 64'h0);
        check("rst_alu_aux", 64'(bus0.alu_aux), 64'h0);

        // Single add from requester 0 on the first edge after release.
        rst = 1'b0;
        bus0.req_valid = 2'b01;
        bus0.req0_op1  = 32'd5;    bus0.req0_op2 = 32'd7;
        bus0.req0_fun3 = FUN3_ADD_SUB;
        bus0.req0_aux  = 1'b0;
        bus0.resp_ready = 2'b01;
        #1;
        check("add_req_ready", 64'(bus0.req_ready), 64'h1);
        check("add_alu_op1", 64'(bus0.alu_op1), 64'd5);
        check("add_alu_op2", 64'(bus0.alu_op2), 64'd7);
        step();
        check("add_resp_valid", 64'(bus0.resp_valid), 64'h1);
        check("add_resp_result", 64'(bus0.resp_result), 64'd12);
        bus0.req_valid = 2'b00;
        #1;
        check("add_no_req_ready", 64'(bus0.req_ready), 64'h0);
        step();
        check("add_back_idle", 64'(bus0.resp_valid), 64'h0);

        // Idle with no requests; response readiness must not start anything.
        bus0.resp_ready = 2'b11;
        #1;
        check("idle_alu_op1", 64'(bus0.alu_op1), 64'h0);
        check("idle_alu_op2", 64'(bus0.alu_op2), 64'h0);
        check("idle_alu_fun3", 64'(bus0.alu_fun3), 64'h0);
        check("idle_alu_aux", 64'(bus0.alu_aux), 64'h0);
        for (int i = 0; i < 2; i++) begin
            step();
            check("idle_resp_valid", 64'(bus0.resp_valid), 64'h0);
            check("idle_req_ready", 64'(bus0.req_ready), 64'h0);
        end

        // Owner 1 subtract, then held for 3 cycles; non-owner resp_ready ignored.
        bus0.req_valid  = 2'b10;
        bus0.req1_op1   = 32'd100; bus0.req1_op2 = 32'd3;
        bus0.req1_fun3  = FUN3_ADD_SUB;
        bus0.req1_aux   = 1'b1;
        bus0.resp_ready = 2'b00;
        #1;
        check("hold_req_ready_in", 64'(bus0.req_ready), 64'h2);
        check("hold_alu_aux", 64'(bus0.alu_aux), 64'h1);
        step();
        bus0.req_valid  = 2'b11;
        bus0.req1_op1   = 32'd200;
        bus0.resp_ready = 2'b01;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("hold_resp_valid", 64'(bus0.resp_valid), 64'h2);
            check("hold_resp_result", 64'(bus0.resp_result), 64'd97);
            check("hold_req_ready", 64'(bus0.req_ready), 64'h0);
            check("hold_alu_op1", 64'(bus0.alu_op1), 64'h0);
            step();
        end

        // Reset while holding discards the result immediately.
        rst = 1'b1;
        #1;
        check("rst_hold_resp_valid", 64'(bus0.resp_valid), 64'h0);
        check("rst_hold_resp_result", 64'(bus0.resp_result), 64'h0);
        check("rst_hold_req_ready", 64'(bus0.req_ready), 64'h0);
        step();
        rst = 1'b0;

        // Both requesting with both responses taken: 0,1,0,1 vs always 0.
        bus0.resp_ready = 2'b11;
        bus0.req0_fun3 = FUN3_ADD_SUB; bus0.req0_aux = 1'b0;
        bus0.req1_fun3 = FUN3_OR;      bus0.req1_aux = 1'b0;
        for (int k = 0; k < 4; k++) begin
            logic        g;
            logic [31:0] r0, r1;
            g  = k[0];
            r0 = 32'(k + 1 + 16);
            r1 = 32'hF0 | 32'(k);
            bus0.req0_op1 = 32'(k + 1); bus0.req0_op2 = 32'h10;
            bus0.req1_op1 = 32'hF0;     bus0.req1_op2 = 32'(k);
            #1;
            check("rr_req_ready", 64'(bus0.req_ready), 64'(owner_onehot(g)));
            check("fix_req_ready", 64'(bus1.req_ready), 64'h1);
            check("rr_alu_fun3", 64'(bus0.alu_fun3), g ? 64'(FUN3_OR) : 64'(FUN3_ADD_SUB));
            step();
            check("rr_resp_valid", 64'(bus0.resp_valid), 64'(owner_onehot(g)));
            check("rr_resp_result", 64'(bus0.resp_result), g ? 64'(r1) : 64'(r0));
            check("fix_resp_valid", 64'(bus1.resp_valid), 64'h1);
            check("fix_resp_result", 64'(bus1.resp_result), 64'(r0));
        end
        bus0.req_valid = 2'b00;
        step();
        check("rr_drain", 64'(bus0.resp_valid), 64'h0);
        check("fix_drain", 64'(bus1.resp_valid), 64'h0);

        // Back-to-back ops from requester 0 across the remaining opcodes.
        bus0.req_valid  = 2'b01;
        bus0.resp_ready = 2'b01;
        foreach (vecs[i]) begin
            bus0.req0_fun3 = vecs[i].f;
            bus0.req0_aux  = vecs[i].aux;
            bus0.req0_op1  = vecs[i].a;
            bus0.req0_op2  = vecs[i].b;
            step();
            check("ops_resp_valid", 64'(bus0.resp_valid), 64'h1);
            check("ops_resp_result", 64'(bus0.resp_result), 64'(vecs[i].r));
        end
        bus0.req_valid = 2'b00;
        step();
        check("ops_drain", 64'(bus0.resp_valid), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
